router_ctrl: RTL and testbench
==============================

# router_ctrl

Control block for the 1x3 router: a Moore state machine that sequences the input register/parity datapath (`detect_add`, `lfd_state`, `ld_state`, `full_state`, `laf_state`, `rst_int_reg`) and the per-port write/valid/timeout logic for the three output FIFOs. It sits between the input interface, the register/parity block and the three FIFOs. It latches the destination address, routes write enables and full status, and aborts a packet when its destination is not read within the timeout.

## Interface
- `NPORT`, 3: number of output ports; addresses 0..2 are valid, address 3 is discarded.
- `TIMEOUT`, 30: consecutive unread-valid cycles before a port's soft reset.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pkt_valid`  in  1  input packet byte valid.
- `data_in`  in  2  address bits [1:0] of the input byte.
- `parity_done`  in  1  from register block.
- `low_packet_valid`  in  1  from register block.
- `empty`  in  3  per-FIFO empty.
- `full`  in  3  per-FIFO full.
- `read_enb`  in  3  per-port read strobe from the output side.
- `detect_add`, `lfd_state`, `ld_state`, `full_state`, `laf_state`, `rst_int_reg`  out  1 each  state strobes to the register block.
- `busy`  out  1  input stall to the source.
- `fifo_full`  out  1  `full` of the latched port.
- `write_enb`  out  3  one-hot FIFO write enable.
- `vld_out`  out  3  per-port data available.
- `soft_reset`  out  3  per-port timeout flush pulse.

## Operation
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE).
- Transitions:
  - DA: `pkt_valid` and addr≠3 and `empty[addr]` → LFD. `pkt_valid` and addr≠3 and not empty → WTE. Otherwise stay; a packet with addr 3 is ignored.
  - LFD → LD, unconditionally.
  - LD: `fifo_full` → FFS; else `!pkt_valid` → LP; else stay.
  - FFS: `!fifo_full` → LAF; else stay.
  - LAF: `parity_done` → DA; else `low_packet_valid` → LP; else → LD.
  - LP → CPE.
  - CPE: `fifo_full` → FFS; else → DA.
  - WTE: `empty[addr_q]` → LFD; else stay.
- Abort: in any state except DA, `soft_reset[addr_q]` forces DA on the next edge. It has priority over all transitions except `reset`. A soft reset on any other port has no FSM effect.
- Address: `addr_q` captures `data_in` when in DA with `pkt_valid`. DA decodes the live `data_in`; all other states use `addr_q`.
- Decoded outputs, all combinational from the state register:
  - `detect_add`=DA, `lfd_state`=LFD, `ld_state`=LD, `full_state`=FFS, `laf_state`=LAF, `rst_int_reg`=CPE.
  - `busy` = not (DA or LD).
  - Internal `wr_en` = LD | LP | LAF.
- `write_enb` = one-hot(`addr_q`) when `wr_en`, else 0. It is never asserted for addr 3.
- `fifo_full` = `full[addr_q]`; 0 if `addr_q`=3.
- `vld_out[i]` = `!empty[i]`, combinational.
- Timeout, per port:
  - Counter increments while `vld_out[i] & !read_enb[i]`.
  - Counter clears on `read_enb[i]` or `!vld_out[i]`.
  - When the count reaches TIMEOUT-1, the next edge registers `soft_reset[i]`=1 for exactly one cycle and clears the counter.

## Timing
- Reset values: state DA, `addr_q`=0, counters 0, `soft_reset`=0. Resulting outputs: `detect_add`=1, all other strobes 0, `busy`=0, `write_enb`=0.
- Each transition takes one cycle. LFD lasts exactly one cycle; LP and CPE last exactly one cycle each.
- From DA with a valid header to `lfd_state` is 1 cycle; `write_enb` follows 1 cycle later (LD).
- `soft_reset[i]` rises on the TIMEOUT-th consecutive unread-valid edge. A `read_enb[i]` in that cycle suppresses it.
- `reset` mid-packet returns to DA on the next edge regardless of state.

## Structure
- Shared package `router_pkg`:
  - state enum (3-bit encoding);
  - `NPORT`, `ADDR_W`=2, `TIMEOUT`, `DROP_ADDR`=2'b11.
- Sub-module `router_sync_timer`: one per port, inputs `vld`/`read_enb`, output `soft_reset`. Instantiated NPORT times.

## Test plan
- Header 0x05 (addr 1), `empty`=3'b111 → LFD next cycle. `write_enb`=3'b010 during LD; `busy` rises in LFD.
- Header addr 2 with `empty[2]`=0 → WTE with `busy`=1. Drop `empty[2]` after 4 cycles → LFD next cycle.
- In LD, raise `full[1]` (addr 1) → FFS, `write_enb`=0. Release → LAF. With `parity_done`=0 and `low_packet_valid`=1 → LP → CPE → DA.
- `pkt_valid` falls in LD → LP, CPE with `rst_int_reg`=1 for one cycle, then DA.
- Header addr 3 → FSM stays in DA, `write_enb` stays 0, `busy` stays 0.
- Hold `empty[0]`=0 and `read_enb[0]`=0 for 30 cycles while in LD for addr 0 → `soft_reset`=3'b001 for one cycle, FSM back to DA. A single read at cycle 29 → no pulse.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
package router_pkg;

   localparam int NPORT   = 3;
   localparam int ADDR_W  = 2;
   localparam int NSLOT   = 1 << ADDR_W;
   localparam int TIMEOUT = 30;
   localparam logic [ADDR_W-1:0] DROP_ADDR = 2'b11;

   typedef enum logic [2:0] {
      ST_DA  = 3'd0,
      ST_LFD = 3'd1,
      ST_LD  = 3'd2,
      ST_FFS = 3'd3,
      ST_LAF = 3'd4,
      ST_LP  = 3'd5,
      ST_CPE = 3'd6,
      ST_WTE = 3'd7
   } state_e;

endpackage

// File: rtl/router_sync_timer.sv
// Per-port read timeout: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_sync_timer #(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic reset,
   input  logic vld,
   input  logic read_enb,
   output logic soft_reset
);

   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             soft_reset_q, soft_reset_d;

   always_comb begin
      cnt_d        = cnt_q;
      soft_reset_d = 1'b0;
      if (!vld || read_enb) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
         cnt_d        = '0;
         soft_reset_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         soft_reset_q <= soft_reset_d;
      end
   end

   assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_ctrl.sv
// Router control FSM: sequences the register/parity block, steers FIFO
// writes to the latched port and aborts packets on a port timeout.
module router_ctrl
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              parity_done,
   input  logic              low_packet_valid,
   input  logic [NPORT-1:0]  empty,
   input  logic [NPORT-1:0]  full,
   input  logic [NPORT-1:0]  read_enb,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              full_state,
   output logic              laf_state,
   output logic              rst_int_reg,
   output logic              busy,
   output logic              fifo_full,
   output logic [NPORT-1:0]  write_enb,
   output logic [NPORT-1:0]  vld_out,
   output logic [NPORT-1:0]  soft_reset
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en;

   // Pad per-port vectors to the full address space so the drop address
   // indexes a constant zero instead of running off the end.
   logic [NSLOT-1:0] empty_ext, full_ext, sreset_ext, onehot_ext;

   assign empty_ext  = {{(NSLOT-NPORT){1'b0}}, empty};
   assign full_ext   = {{(NSLOT-NPORT){1'b0}}, full};
   assign sreset_ext = {{(NSLOT-NPORT){1'b0}}, soft_reset};
   assign onehot_ext = NSLOT'(1) << addr_q;

   assign vld_out = ~empty;

   for (genvar i = 0; i < NPORT; i++) begin : g_timer
      router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
         .clock      (clock),
         .reset      (reset),
         .vld        (vld_out[i]),
         .read_enb   (read_enb[i]),
         .soft_reset (soft_reset[i])
      );
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == ST_DA && pkt_valid) addr_d = data_in;

      case (state_q)
         ST_DA:  if (pkt_valid && data_in != DROP_ADDR)
                    state_d = empty_ext[data_in] ? ST_LFD : ST_WTE;
         ST_LFD: state_d = ST_LD;
         ST_LD:  if (fifo_full)       state_d = ST_FFS;
                 else if (!pkt_valid) state_d = ST_LP;
         ST_FFS: if (!fifo_full) state_d = ST_LAF;
         ST_LAF: if (parity_done)           state_d = ST_DA;
                 else if (low_packet_valid) state_d = ST_LP;
                 else                       state_d = ST_LD;
         ST_LP:  state_d = ST_CPE;
         ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
         ST_WTE: if (empty_ext[addr_q]) state_d = ST_LFD;
         default: state_d = ST_DA;
      endcase

      // Timeout on the packet's own port abandons it from anywhere.
      if (state_q != ST_DA && sreset_ext[addr_q]) state_d = ST_DA;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_DA;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign detect_add  = (state_q == ST_DA);
   assign lfd_state   = (state_q == ST_LFD);
   assign ld_state    = (state_q == ST_LD);
   assign full_state  = (state_q == ST_FFS);
   assign laf_state   = (state_q == ST_LAF);
   assign rst_int_reg = (state_q == ST_CPE);
   assign busy        = !(detect_add || ld_state);
   assign wr_en       = ld_state || laf_state || (state_q == ST_LP);
   assign write_enb   = wr_en ? onehot_ext[NPORT-1:0] : '0;
   assign fifo_full   = full_ext[addr_q];

endmodule

// File: tb/tb_router_ctrl.sv
// Directed-vector bench for router_ctrl with hand-computed expectations.
module tb_router_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       parity_done;
   logic       low_packet_valid;
   logic [2:0] empty, full, read_enb;
   logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
   logic       busy, fifo_full;
   logic [2:0] write_enb, vld_out, soft_reset;

   int vectors = 0;
   int miscompares = 0;

   router_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .empty            (empty),
      .full             (full),
      .read_enb         (read_enb),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .full_state       (full_state),
      .laf_state        (laf_state),
      .rst_int_reg      (rst_int_reg),
      .busy             (busy),
      .fifo_full        (fifo_full),
      .write_enb        (write_enb),
      .vld_out          (vld_out),
      .soft_reset       (soft_reset)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Packs the six strobes as {da,lfd,ld,ffs,laf,cpe} for compact checks.
   function automatic logic [5:0] strobes();
      return {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg};
   endfunction

   task automatic test_reset();
      reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
      low_packet_valid = 1'b0; empty = 3'b111; full = 3'b000; read_enb = 3'b000;
      step(); step();
      reset = 1'b0;
      vectors++;
      if (strobes() !== 6'b100000) begin
         miscompares++; $display("FAIL reset_strobes: got %b want 100000", strobes());
      end
      vectors++;
      if (busy !== 1'b0 || write_enb !== 3'b000 || soft_reset !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_outs: busy=%b we=%b sr=%b want 0 000 000", busy, write_enb, soft_reset);
      end
   endtask

   task automatic test_full_path();
      pkt_valid = 1'b1; data_in = 2'b01;
      step();
      vectors++;
      if (strobes() !== 6'b010000 || busy !== 1'b1) begin
         miscompares++; $display("FAIL hdr_lfd: strobes=%b busy=%b want 010000 1", strobes(), busy);
      end
      step();
      vectors++;
      if (strobes() !== 6'b001000 || write_enb !== 3'b010 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ld_write: strobes=%b we=%b busy=%b want 001000 010 0", strobes(), write_enb, busy);
      end
      full = 3'b010;
      step();
      vectors++;
      if (strobes() !== 6'b000100 || write_enb !== 3'b000 || fifo_full !== 1'b1) begin
         miscompares++;
         $display("FAIL ffs: strobes=%b we=%b ff=%b want 000100 000 1", strobes(), write_enb, fifo_full);
      end
      full = 3'b000; pkt_valid = 1'b0; low_packet_valid = 1'b1;
      step();
      vectors++;
      if (strobes() !== 6'b000010 || write_enb !== 3'b010) begin
         miscompares++; $display("FAIL laf: strobes=%b we=%b want 000010 010", strobes(), write_enb);
      end
      step();
      low_packet_valid = 1'b0;
      vectors++;
      if (strobes() !== 6'b000000 || write_enb !== 3'b010 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL laf_lp: strobes=%b we=%b busy=%b want 000000 010 1", strobes(), write_enb, busy);
      end
      step();
      vectors++;
      if (strobes() !== 6'b000001) begin
         miscompares++; $display("FAIL lp_cpe: strobes=%b want 000001", strobes());
      end
      step();
      vectors++;
      if (strobes() !== 6'b100000) begin
         miscompares++; $display("FAIL cpe_da: strobes=%b want 100000", strobes());
      end
   endtask

   task automatic test_pkt_end();
      pkt_valid = 1'b1; data_in = 2'b00;
      step(); step();
      pkt_valid = 1'b0;
      step();
      vectors++;
      if (strobes() !== 6'b000000 || write_enb !== 3'b001) begin
         miscompares++; $display("FAIL end_lp: strobes=%b we=%b want 000000 001", strobes(), write_enb);
      end
      step();
      vectors++;
      if (strobes() !== 6'b000001 || write_enb !== 3'b000) begin
         miscompares++; $display("FAIL end_cpe: strobes=%b we=%b want 000001 000", strobes(), write_enb);
      end
      step();
      vectors++;
      if (strobes() !== 6'b100000) begin
         miscompares++; $display("FAIL end_da: strobes=%b want 100000", strobes());
      end
   endtask

   task automatic test_wait_empty();
      empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
      step();
      pkt_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (strobes() !== 6'b000000 || busy !== 1'b1 || vld_out !== 3'b100) begin
            miscompares++;
            $display("FAIL wte_hold[%0d]: strobes=%b busy=%b vld=%b want 000000 1 100",
                     i, strobes(), busy, vld_out);
         end
         if (i < 3) step();
      end
      empty = 3'b111;
      step();
      vectors++;
      if (strobes() !== 6'b010000) begin
         miscompares++; $display("FAIL wte_lfd: strobes=%b want 010000", strobes());
      end
      step();
      vectors++;
      if (write_enb !== 3'b100) begin
         miscompares++; $display("FAIL wte_we: we=%b want 100", write_enb);
      end
      step(); step(); step();
      vectors++;
      if (strobes() !== 6'b100000) begin
         miscompares++; $display("FAIL wte_done: strobes=%b want 100000", strobes());
      end
   endtask

   task automatic test_drop_addr();
      pkt_valid = 1'b1; data_in = 2'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (strobes() !== 6'b100000 || busy !== 1'b0 || write_enb !== 3'b000) begin
            miscompares++;
            $display("FAIL drop[%0d]: strobes=%b busy=%b we=%b want 100000 0 000",
                     i, strobes(), busy, write_enb);
         end
      end
      pkt_valid = 1'b0; full = 3'b111;
      #1;
      vectors++;
      if (fifo_full !== 1'b0) begin
         miscompares++; $display("FAIL drop_ff: fifo_full=%b want 0", fifo_full);
      end
      full = 3'b000;
   endtask

   task automatic test_reset_mid();
      pkt_valid = 1'b1; data_in = 2'd1;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0; pkt_valid = 1'b0;
      vectors++;
      if (strobes() !== 6'b100000 || write_enb !== 3'b000) begin
         miscompares++; $display("FAIL mid_reset: strobes=%b we=%b want 100000 000", strobes(), write_enb);
      end
   endtask

   task automatic test_timeout();
      pkt_valid = 1'b1; data_in = 2'd0;
      step(); step();
      empty = 3'b110;
      for (int e = 1; e <= 29; e++) begin
         step();
         vectors++;
         if (soft_reset !== 3'b000 || ld_state !== 1'b1) begin
            miscompares++;
            $display("FAIL to_count[%0d]: sr=%b ld=%b want 000 1", e, soft_reset, ld_state);
         end
      end
      step();
      pkt_valid = 1'b0;
      vectors++;
      if (soft_reset !== 3'b001 || ld_state !== 1'b1) begin
         miscompares++; $display("FAIL to_pulse: sr=%b ld=%b want 001 1", soft_reset, ld_state);
      end
      step();
      vectors++;
      if (soft_reset !== 3'b000 || strobes() !== 6'b100000) begin
         miscompares++; $display("FAIL to_abort: sr=%b strobes=%b want 000 100000", soft_reset, strobes());
      end
      empty = 3'b111;
      step();
      // Single read on the 29th edge restarts the count: nothing by edge 45.
      empty = 3'b110;
      for (int e = 1; e <= 45; e++) begin
         read_enb = (e == 29) ? 3'b001 : 3'b000;
         step();
         vectors++;
         if (soft_reset !== 3'b000) begin
            miscompares++; $display("FAIL to_read29[%0d]: sr=%b want 000", e, soft_reset);
         end
      end
      read_enb = 3'b000; empty = 3'b111;
      step();
      // Read landing on the would-be pulse edge suppresses it.
      empty = 3'b110;
      for (int e = 1; e <= 32; e++) begin
         read_enb = (e == 30) ? 3'b001 : 3'b000;
         step();
         vectors++;
         if (soft_reset !== 3'b000) begin
            miscompares++; $display("FAIL to_read30[%0d]: sr=%b want 000", e, soft_reset);
         end
      end
      read_enb = 3'b000; empty = 3'b111;
      step();
   endtask

   initial begin
      test_reset();
      test_full_path();
      test_pkt_end();
      test_wait_empty();
      test_drop_addr();
      test_reset_mid();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
